// File: rtl/mul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_sequencer_pkg
// Shared MIPS-core definitions used by the multi-cycle multiplier sequencer:
//   - default operand width of the integer datapath
//   - ALUControl code that selects MUL in the EX stage
//   - primary opcode / R-type funct constants of the decoder
//   - state encoding of the multiplier sequencer FSM
// -----------------------------------------------------------------------------
package mul_sequencer_pkg;

    // Integer datapath width of the core.
    localparam int MUL_WIDTH = 32;

    // ALUControl encodings (EX stage).
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_MUL = 3'b101;

    // Primary opcodes.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct field values.
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    // Multiplier sequencer states.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // True when the EX-stage ALUControl requests a multiply.
    function automatic logic is_mul(input logic [2:0] alu_control);
        return alu_control == ALU_MUL;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mul_shift_add_dp
// Radix-2 shift-add multiplier datapath. Holds the latched multiplicand and
// multiplier, the 2*WIDTH accumulator, and the result registers presented to
// the pipeline. Sequencing (when to load, step and capture) comes from the FSM
// in mul_sequencer.
//
// Ports:
//   clk        clock, all state on rising edge
//   srst       synchronous active-high reset, clears every register
//   load       latch src_a/src_b, clear accumulator
//   step       perform one shift-add iteration
//   capture    on the final iteration, copy the finished accumulator value
//              into product/product_hi
//   src_a      multiplicand
//   src_b      multiplier
//   product    low word of the last completed product
//   product_hi high word (unsigned) of the last completed product
// -----------------------------------------------------------------------------
module mul_shift_add_dp
    #(
        parameter int WIDTH = 32
    )
    (
        input  logic             clk,
        input  logic             srst,
        input  logic             load,
        input  logic             step,
        input  logic             capture,
        input  logic [WIDTH-1:0] src_a,
        input  logic [WIDTH-1:0] src_b,
        output logic [WIDTH-1:0] product,
        output logic [WIDTH-1:0] product_hi
    );

    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   product_reg;
    logic [WIDTH-1:0]   product_hi_reg;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;

    // Partial product for this iteration: multiplicand gated by the current
    // multiplier LSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // The add keeps its carry (WIDTH+1 bits); the carry becomes the new MSB
    // after the right shift, so nothing is lost across iterations.
    always_comb begin
        sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= src_a;
            mplier_reg <= src_b;
            acc_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            mplier_reg <= mplier_reg >> 1;
        end
    end

    // Result registers only move on a completed operation, so an aborted
    // multiply leaves the previous result visible.
    always_ff @(posedge clk) begin
        if (srst) begin
            product_reg    <= '0;
            product_hi_reg <= '0;
        end else if (capture) begin
            product_reg    <= acc_next[WIDTH-1:0];
            product_hi_reg <= acc_next[2*WIDTH-1:WIDTH];
        end
    end

    assign product    = product_reg;
    assign product_hi = product_hi_reg;

endmodule

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Multi-cycle MUL unit for the EX stage of a 5-stage MIPS pipeline. A start
// request latches the operands and runs CYCLES shift-add iterations while
// stalling the front of the pipeline; the result is presented with a one-cycle
// Done pulse during which the pipeline is released to capture it.
//
// Ports:
//   CLK        clock, all state on rising edge
//   RST        synchronous active-high reset (priority over everything)
//   Start      EX-stage instruction is MUL
//   SrcA       multiplicand, sampled only when a start is accepted
//   SrcB       multiplier, sampled only when a start is accepted
//   Flush      abort any operation in progress; also blocks a start
//   Stall      freeze IF/ID/EX while high (combinational)
//   Done       one-cycle pulse, Product/ProductHi valid
//   Product    low word of SrcA*SrcB
//   ProductHi  unsigned high word of SrcA*SrcB
// -----------------------------------------------------------------------------
module mul_sequencer
    import mul_sequencer_pkg::*;
    #(
        parameter int WIDTH  = MUL_WIDTH,
        parameter int CYCLES = WIDTH
    )
    (
        input  logic             CLK,
        input  logic             RST,
        input  logic             Start,
        input  logic [WIDTH-1:0] SrcA,
        input  logic [WIDTH-1:0] SrcB,
        input  logic             Flush,
        output logic             Stall,
        output logic             Done,
        output logic [WIDTH-1:0] Product,
        output logic [WIDTH-1:0] ProductHi
    );

    // Counter only needs to reach CYCLES-1.
    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    mul_state_t       state_reg;
    mul_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic             load;
    logic             step;
    logic             capture;
    logic             stall;
    logic             accept;

    // A start is taken only when Flush is low; Flush always wins.
    assign accept = Start & ~Flush;

    // -------------------------------------------------------------------------
    // State and iteration counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= MUL_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        stall      = 1'b0;

        unique case (state_reg)
            MUL_IDLE: begin
                // Stall is raised in the same cycle the MUL reaches EX so the
                // instruction is held there from its very first cycle.
                if (accept) begin
                    stall      = 1'b1;
                    load       = 1'b1;
                    count_next = '0;
                    state_next = MUL_RUN;
                end
            end

            MUL_RUN: begin
                // Start is deliberately ignored here: operands stay latched.
                stall = 1'b1;
                step  = 1'b1;
                if (Flush) begin
                    count_next = '0;
                    state_next = MUL_IDLE;
                end else if (count_reg == CNT_LAST) begin
                    capture    = 1'b1;
                    count_next = '0;
                    state_next = MUL_DONE;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

            MUL_DONE: begin
                // Stall stays low so the pipeline advances and picks up the
                // result; a following MUL may be accepted straight away.
                if (accept) begin
                    load       = 1'b1;
                    count_next = '0;
                    state_next = MUL_RUN;
                end else begin
                    state_next = MUL_IDLE;
                end
            end

            default: begin
                count_next = '0;
                state_next = MUL_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift-add datapath
    // -------------------------------------------------------------------------
    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (CLK),
        .srst       (RST),
        .load       (load),
        .step       (step),
        .capture    (capture),
        .src_a      (SrcA),
        .src_b      (SrcB),
        .product    (Product),
        .product_hi (ProductHi)
    );

    assign Stall = stall;
    assign Done  = (state_reg == MUL_DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Self-checking bench for mul_sequencer (default WIDTH=32). Expected products
// come from a plain 64-bit multiply; expected timing from the stated latency.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 1;   // cycles from Start cycle to Done cycle

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic         Flush;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Stall;
    logic         Done;
    logic [W-1:0] Product;
    logic [W-1:0] ProductHi;

    int checks   = 0;
    int failures = 0;

    // Last completed result, as the outputs should be holding it.
    logic [W-1:0] held_lo = '0;
    logic [W-1:0] held_hi = '0;

    always #5 CLK = ~CLK;

    mul_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Flush     (Flush),
        .Stall     (Stall),
        .Done      (Done),
        .Product   (Product),
        .ProductHi (ProductHi)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // One isolated multiply with a single-cycle Start. Operands are scrambled
    // after the accept cycle so a late re-latch would corrupt the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int stall_cnt, output int latency,
                          output logic [W-1:0] lo, output logic [W-1:0] hi,
                          output logic done_stall, output logic done_after,
                          output logic timeout);
        int cyc;
        timeout = 1'b0;
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b0; SrcA = a; SrcB = b;
        #1;
        stall_cnt = Stall ? 1 : 0;
        @(negedge CLK);
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        cyc = 1;
        while (1) begin
            #1;
            if (Done) break;
            if (Stall) stall_cnt++;
            if (cyc >= 200) begin
                timeout = 1'b1;
                break;
            end
            @(negedge CLK);
            SrcA = $urandom; SrcB = $urandom;
            cyc++;
        end
        latency    = cyc;
        lo         = Product;
        hi         = ProductHi;
        done_stall = Stall;
        @(negedge CLK);
        #1;
        done_after = Done;
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b0; Flush = 1'b0; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Product !== '0) begin failures++; $display("FAIL reset_product got=%h exp=0", Product); end
        checks++; if (ProductHi !== '0) begin failures++; $display("FAIL reset_product_hi got=%h exp=0", ProductHi); end
        // Stall follows Start combinationally in IDLE; drop Start before the
        // edge so nothing is accepted.
        Start = 1'b1;
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL idle_start_stall got=%b exp=1", Stall); end
        Start = 1'b0;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL idle_nostart_stall got=%b exp=0", Stall); end
        held_lo = '0; held_hi = '0;
        $display("tb: reset checked");
    endtask

    task automatic test_basic();
        int sc, lat;
        logic [W-1:0] lo, hi;
        logic ds, da, to;
        run_op(32'd3, 32'd5, sc, lat, lo, hi, ds, da, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++; if (sc != LAT) begin failures++; $display("FAIL basic_stall_cycles got=%0d exp=%0d", sc, LAT); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (lo !== 32'h0000000F) begin failures++; $display("FAIL basic_product got=%h exp=0000000f", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL basic_product_hi got=%h exp=0", hi); end
        checks++; if (ds !== 1'b0) begin failures++; $display("FAIL basic_done_stall got=%b exp=0", ds); end
        checks++; if (da !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", da); end
        held_lo = 32'h0000000F; held_hi = '0;
        $display("tb: 3*5 -> %h_%h latency=%0d stall=%0d", hi, lo, lat, sc);
    endtask

    task automatic test_corners();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] el [5];
        logic [W-1:0] eh [5];
        int sc, lat;
        logic [W-1:0] lo, hi;
        logic ds, da, to;
        va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; el[0] = 32'h00000001; eh[0] = 32'hFFFFFFFE;
        va[1] = 32'hFFFFFFFD; vb[1] = 32'h00000007; el[1] = 32'hFFFFFFEB; eh[1] = 32'h00000006;
        va[2] = 32'h00000000; vb[2] = 32'h12345678; el[2] = 32'h00000000; eh[2] = 32'h00000000;
        va[3] = 32'h80000000; vb[3] = 32'h00000002; el[3] = 32'h00000000; eh[3] = 32'h00000001;
        va[4] = 32'hDEADBEEF; vb[4] = 32'h00000001; el[4] = 32'hDEADBEEF; eh[4] = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], sc, lat, lo, hi, ds, da, to);
            checks++; if (to) begin failures++; $display("FAIL corner%0d_timeout got=timeout exp=done", i); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL corner%0d_product got=%h exp=%h", i, lo, el[i]); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL corner%0d_product_hi got=%h exp=%h", i, hi, eh[i]); end
            held_lo = el[i]; held_hi = eh[i];
            $display("tb: %h*%h -> %h_%h", va[i], vb[i], hi, lo);
        end
    endtask

    task automatic test_random();
        int sc, lat;
        logic [W-1:0] a, b, lo, hi;
        logic [2*W-1:0] exp;
        logic ds, da, to;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) b = '1;
            exp = ref_mul(a, b);
            run_op(a, b, sc, lat, lo, hi, ds, da, to);
            checks++; if (to || lat != LAT) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL rand%0d_product got=%h_%h exp=%h", i, hi, lo, exp); end
            held_lo = exp[W-1:0]; held_hi = exp[2*W-1:W];
            $display("tb: rand %h*%h -> %h_%h", a, b, hi, lo);
        end
    endtask

    task automatic test_flush();
        logic saw_done;
        @(negedge CLK);
        Start = 1'b1; SrcA = $urandom; SrcB = $urandom;
        @(negedge CLK);
        Start = 1'b0;
        repeat (10) @(negedge CLK);
        Flush = 1'b1;
        #1;
        checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL flush_run_stall got=%b exp=1", Stall); end
        @(negedge CLK);
        Flush = 1'b0;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", Stall); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", Done); end
        checks++; if ({ProductHi, Product} !== {held_hi, held_lo}) begin
            failures++; $display("FAIL flush_product got=%h_%h exp=%h_%h", ProductHi, Product, held_hi, held_lo);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge CLK); #1;
            if (Done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL flush_late_done got=1 exp=0"); end
        checks++; if ({ProductHi, Product} !== {held_hi, held_lo}) begin
            failures++; $display("FAIL flush_hold got=%h_%h exp=%h_%h", ProductHi, Product, held_hi, held_lo);
        end
        $display("tb: flush at iteration 10 -> idle, product %h_%h held", ProductHi, Product);
    endtask

    task automatic test_start_flush();
        logic saw_stall;
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b1; SrcA = $urandom; SrcB = $urandom;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL startflush_stall got=%b exp=0", Stall); end
        @(negedge CLK);
        Start = 1'b0; Flush = 1'b0;
        saw_stall = 1'b0;
        repeat (40) begin
            #1;
            if (Stall || Done) saw_stall = 1'b1;
            @(negedge CLK);
        end
        checks++; if (saw_stall) begin failures++; $display("FAIL startflush_accepted got=1 exp=0"); end
        $display("tb: start with flush -> not accepted");
    endtask

    task automatic test_reset_mid_run();
        int sc, lat;
        logic [W-1:0] lo, hi;
        logic ds, da, to, saw_done;
        @(negedge CLK);
        Start = 1'b1; SrcA = 32'hDEADBEEF; SrcB = 32'h00001234;
        @(negedge CLK);
        Start = 1'b0;
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if ({Stall, Done} !== 2'b00) begin failures++; $display("FAIL rst_run_ctrl got=%b%b exp=00", Stall, Done); end
        checks++; if ({ProductHi, Product} !== '0) begin failures++; $display("FAIL rst_run_product got=%h_%h exp=0", ProductHi, Product); end
        held_lo = '0; held_hi = '0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge CLK); #1;
            if (Done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin failures++; $display("FAIL rst_run_done got=1 exp=0"); end
        run_op(32'd2, 32'd3, sc, lat, lo, hi, ds, da, to);
        checks++; if (to || lat != LAT) begin failures++; $display("FAIL rst_rerun_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (lo !== 32'd6 || hi !== 32'd0) begin failures++; $display("FAIL rst_rerun_product got=%h_%h exp=0_6", hi, lo); end
        held_lo = 32'd6; held_hi = '0;
        $display("tb: reset mid-run, then 2*3 -> %h latency=%0d", lo, lat);
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2;
        logic to;
        to = 1'b0; d1 = 0; d2 = 0;
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b0; SrcA = 32'd4; SrcB = 32'd4;
        @(negedge CLK);
        cyc = 1;
        // Start stays high throughout RUN with junk operands: must be ignored.
        SrcA = $urandom; SrcB = $urandom;
        while (1) begin
            #1;
            if (Done) break;
            if (cyc >= 200) begin to = 1'b1; break; end
            @(negedge CLK); cyc++;
            SrcA = $urandom; SrcB = $urandom;
        end
        d1 = cyc;
        checks++; if (to || d1 != LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", d1, LAT); end
        checks++; if (Product !== 32'd16) begin failures++; $display("FAIL b2b_first_product got=%h exp=10", Product); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL b2b_done_stall got=%b exp=0", Stall); end
        SrcA = 32'd6; SrcB = 32'd7;
        @(negedge CLK); cyc++;
        SrcA = $urandom; SrcB = $urandom;
        while (1) begin
            #1;
            if (Done) break;
            if (cyc >= 400) begin to = 1'b1; break; end
            @(negedge CLK); cyc++;
            SrcA = $urandom; SrcB = $urandom;
        end
        d2 = cyc;
        Start = 1'b0;
        checks++; if (to || (d2 - d1) != LAT) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", d2 - d1, LAT); end
        checks++; if (Product !== 32'd42 || ProductHi !== '0) begin failures++; $display("FAIL b2b_second_product got=%h_%h exp=0_2a", ProductHi, Product); end
        @(negedge CLK); #1;
        checks++; if (Done !== 1'b0 || Product !== 32'd42) begin failures++; $display("FAIL b2b_after got=%b/%h exp=0/2a", Done, Product); end
        held_lo = 32'd42; held_hi = '0;
        $display("tb: back-to-back 4*4 then 6*7, done at %0d and %0d", d1, d2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_flush();
        test_start_flush();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CYCLES, default WIDTH, number of RUN iterations (one operand bit per cycle).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  EX-stage instruction is MUL (ALUControl == 3'b101); request to multiply.
REQ-006 SrcA  input  WIDTH  multiplicand, sampled only when a Start is accepted.
REQ-007 SrcB  input  WIDTH  multiplier, sampled only when a Start is accepted.
REQ-008 Flush  input  1  abort any operation in progress (branch/jump flush).
REQ-009 Stall  output  1  freeze IF/ID/EX pipeline registers while high.
REQ-010 Done  output  1  one-cycle pulse; Product/ProductHi valid.
REQ-011 Product  output  WIDTH  low word of SrcA*SrcB (identical for signed and unsigned operands).
REQ-012 ProductHi  output  WIDTH  unsigned high word of SrcA*SrcB.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: Start=1 and Flush=0 at edge -> latch SrcA/SrcB, clear 2*WIDTH accumulator and iteration counter, go RUN; otherwise stay IDLE.
REQ-015 RUN: each edge, if multiplier LSB=1, add multiplicand into accumulator upper half, then shift accumulator and multiplier right by one; counter increments.
REQ-016 RUN -> DONE on the edge where counter reaches CYCLES-1; exactly CYCLES edges spent in RUN.
REQ-017 DONE: Done=1 for exactly one cycle; Product/ProductHi driven from accumulator.
REQ-018 DONE -> RUN if Start=1 and Flush=0 (back-to-back accepted, new operands latched); else -> IDLE.
REQ-019 Latency: Start accepted at edge k -> Done high in cycle after edge k+CYCLES (33 cycles for default).
REQ-020 Stall = (IDLE and Start and not Flush) or RUN, combinational, so the MUL stays in EX from its first cycle until DONE.
REQ-021 Stall SHALL be low in DONE so the pipeline advances and captures Product that cycle.
REQ-022 Product/ProductHi SHALL hold last result until the next DONE; never change in IDLE.
REQ-023 Start while in RUN SHALL be ignored (no operand re-latch).
REQ-024 Flush in RUN or DONE SHALL force IDLE at next edge; no Done pulse; Product/ProductHi retain previous completed result.
REQ-025 Flush and Start simultaneous: Flush wins; Start not accepted.
REQ-026 Accumulator arithmetic SHALL be WIDTH+1 bits per add (carry kept), 2*WIDTH total; no overflow flag.

Reset
REQ-027 RST at edge SHALL force IDLE, counter=0, accumulator=0, latched operands=0, Product=0, ProductHi=0, Done=0.
REQ-028 Stall SHALL be 0 during the cycle following reset unless Start=1.
REQ-029 RST SHALL take priority over Start and Flush, including mid-RUN; the aborted operation produces no Done.

Structure
REQ-030 State encoding, WIDTH default and MUL ALUControl code 3'b101 SHALL live in the shared MIPS package alongside funct/opcode constants.
REQ-031 Shift-add datapath (accumulator, adder, shifter) MAY be split into sub-module mul_shift_add_dp; FSM and counter SHALL stay in mul_sequencer.

Verification
REQ-032 SrcA=3, SrcB=5, Start 1 cycle -> Stall high 33 cycles, Done at cycle 33, Product=0x0000000F, ProductHi=0.
REQ-033 SrcA=SrcB=0xFFFFFFFF -> Product=0x00000001, ProductHi=0xFFFFFFFE.
REQ-034 SrcA=0xFFFFFFFD (-3), SrcB=7 -> Product=0xFFFFFFEB (-21).
REQ-035 Flush at RUN iteration 10 -> IDLE next cycle, Stall low, no Done, Product unchanged from prior result.
REQ-036 RST at RUN iteration 20 -> all outputs 0 next cycle; new Start 2*3 afterwards -> Product=6 after 33 cycles.
REQ-037 Start held high across DONE of 4*4 with new operands 6*7 -> Done pulses twice, Product=16 then 42, second Done 33 cycles after first.
